// File: rtl/gaussian_window_gen.sv
`default_nettype none
// ==========================================================================
// gaussian_window_gen : raster pixel stream -> packed WIDTH x WIDTH windows
// Rev 1.0
// ==========================================================================
module gaussian_window_gen #(
  parameter int BITS    = 8,
  parameter int WIDTH   = 7,
  parameter int MASKLEN = 392,
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [BITS-1:0]    in_pixel,
  output logic               in_ready,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [MASKLEN-1:0] win_data,
  output logic [15:0]        win_row,
  output logic [15:0]        win_col,
  output logic               frame_done
);

  localparam int          COL_W      = $clog2(IMG_W);
  localparam logic [15:0] C_LAST_COL = 16'(IMG_W - 1);
  localparam logic [15:0] C_LAST_ROW = 16'(IMG_H - 1);
  localparam logic [15:0] C_EDGE     = 16'(WIDTH - 1);
  localparam logic [15:0] C_HALF     = 16'((WIDTH - 1) / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [15:0]        r_row;
  logic [15:0]        r_col;
  logic [BITS-1:0]    r_lb       [WIDTH-1][IMG_W];
  logic [BITS-1:0]    r_win      [WIDTH][WIDTH];
  logic [BITS-1:0]    w_new_col  [WIDTH];
  logic [BITS-1:0]    w_next_win [WIDTH][WIDTH];
  logic [MASKLEN-1:0] w_next_data;
  logic [COL_W-1:0]   w_addr;
  logic               w_accept;
  logic               w_restart;
  logic               w_load;
  logic               w_emit;
  logic               w_done_next;

  always_comb begin
    state_next  = state;
    w_done_next = 1'b0;
    in_ready    = (state != DRAIN) && (!win_valid || win_ready);
    w_accept    = in_valid && in_ready;
    w_restart   = w_accept && in_sof;
    w_load      = w_restart || (w_accept && (state == RUN));
    // only fully covered positions of the current frame produce a window
    w_emit      = w_load && !w_restart && (r_row >= C_EDGE) && (r_col >= C_EDGE);
    case (state)
      IDLE: begin
        if (w_restart) state_next = RUN;
      end
      RUN: begin
        if (w_accept && !in_sof && (r_row == C_LAST_ROW) && (r_col == C_LAST_COL))
          state_next = DRAIN;
      end
      DRAIN: begin
        if (!win_valid || win_ready) begin
          state_next  = IDLE;
          w_done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    w_addr      = w_restart ? '0 : r_col[COL_W-1:0];
    w_next_data = '0;
    for (int i = 0; i < WIDTH - 1; i++) w_new_col[i] = r_lb[i][w_addr];
    w_new_col[WIDTH-1] = in_pixel;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH - 1; j++) w_next_win[i][j] = r_win[i][j+1];
      w_next_win[i][WIDTH-1] = w_new_col[i];
    end
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++)
        w_next_data[(i*WIDTH+j)*BITS +: BITS] = w_next_win[i][j];
    end
  end

  // Line buffers rotate per column: entry 0 holds the oldest row.
  always_ff @(posedge clk) begin
    if (w_load) begin
      for (int k = 0; k < WIDTH - 2; k++) r_lb[k][w_addr] <= r_lb[k+1][w_addr];
      r_lb[WIDTH-2][w_addr] <= in_pixel;
      r_win <= w_next_win;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      r_row      <= '0;
      r_col      <= '0;
      win_valid  <= 1'b0;
      win_data   <= '0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= w_done_next;
      if (w_load) begin
        if (w_restart) begin
          r_row <= '0;
          r_col <= 16'd1;
        end else if (r_col == C_LAST_COL) begin
          r_col <= '0;
          r_row <= r_row + 16'd1;
        end else begin
          r_col <= r_col + 16'd1;
        end
      end
      if (w_emit) begin
        win_valid <= 1'b1;
        win_data  <= w_next_data;
        win_row   <= r_row - C_HALF;
        win_col   <= r_col - C_HALF;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gaussian_window_gen.sv
`default_nettype none
// tb_gaussian_window_gen: scoreboard bench; expected windows are cut from a
// stored image of each frame as pixels are accepted.
module tb_gaussian_window_gen;
  localparam int BITS    = 8;
  localparam int WIDTH   = 7;
  localparam int MASKLEN = 392;
  localparam int IMG_W   = 10;
  localparam int IMG_H   = 8;
  localparam int E66     = (WIDTH*WIDTH-1)*BITS;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_sof = 1'b0;
  logic [BITS-1:0]    in_pixel = '0;
  logic               win_ready = 1'b1;
  logic               in_ready;
  logic               win_valid;
  logic               frame_done;
  logic [MASKLEN-1:0] win_data;
  logic [15:0]        win_row;
  logic [15:0]        win_col;

  gaussian_window_gen #(
    .BITS(BITS), .WIDTH(WIDTH), .MASKLEN(MASKLEN), .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .in_ready(in_ready), .win_valid(win_valid), .win_ready(win_ready),
    .win_data(win_data), .win_row(win_row), .win_col(win_col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MASKLEN-1:0] data;
    logic [15:0]        row;
    logic [15:0]        col;
    int                 acc;
    bit                 last;
  } exp_t;

  exp_t            sb[$];
  logic [BITS-1:0] img [IMG_H][IMG_W];
  bit              m_active = 0;
  bit              m_drain = 0;
  int              m_r = 0;
  int              m_c = 0;
  bit              exp_fd = 0;
  int              cyc = 0;
  int              n_vec = 0;
  int              n_fail = 0;
  int              scn_win = 0;
  int              fd_count = 0;
  int              rdy_mode = 0;
  bit              stall_armed = 0;
  bit              prev_hold = 0;
  logic [MASKLEN-1:0] held_data, first_data, last_data;
  logic [15:0]     held_row, held_col, first_row, first_col, last_row, last_col;

  always @(posedge clk) cyc++;

  function void model_accept(input bit sof, input logic [BITS-1:0] pix);
    exp_t e;
    if (sof) begin
      m_active = 1;
      m_r = 0;
      m_c = 0;
    end
    if (!m_active) return;
    img[m_r][m_c] = pix;
    if (m_r >= WIDTH-1 && m_c >= WIDTH-1) begin
      e.data = '0;
      for (int i = 0; i < WIDTH; i++)
        for (int j = 0; j < WIDTH; j++)
          e.data[(i*WIDTH+j)*BITS +: BITS] = img[m_r-WIDTH+1+i][m_c-WIDTH+1+j];
      e.row  = 16'(m_r - (WIDTH-1)/2);
      e.col  = 16'(m_c - (WIDTH-1)/2);
      e.acc  = cyc;
      e.last = (m_r == IMG_H-1) && (m_c == IMG_W-1);
      sb.push_back(e);
    end
    if (m_r == IMG_H-1 && m_c == IMG_W-1) begin
      m_active = 0;
      m_drain  = 1;
    end else if (m_c == IMG_W-1) begin
      m_c = 0;
      m_r++;
    end else begin
      m_c++;
    end
  endfunction

  // Monitor: samples on the falling edge, ahead of the rising edge that transfers.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_hold = 0;
    end else begin
      n_vec++;
      if (in_ready !== (!m_drain && (!win_valid || win_ready))) begin
        n_fail++;
        $display("FAIL in_ready @%0d: got %b want %b", cyc, in_ready, !m_drain && (!win_valid || win_ready));
      end
      n_vec++;
      if (frame_done !== exp_fd) begin
        n_fail++;
        $display("FAIL frame_done @%0d: got %b want %b", cyc, frame_done, exp_fd);
      end
      if (frame_done) fd_count++;
      exp_fd = 0;
      if (win_valid) begin
        n_vec++;
        if (!prev_hold) begin
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected window @%0d: got row %0d col %0d want none", cyc, win_row, win_col);
          end else if (cyc != sb[0].acc + 1) begin
            n_fail++;
            $display("FAIL window latency: got %0d cycles want 1", cyc - sb[0].acc);
          end
        end else if (win_data !== held_data || win_row !== held_row || win_col !== held_col) begin
          n_fail++;
          $display("FAIL stall stability: got row %0d col %0d data %h want row %0d col %0d data %h",
                   win_row, win_col, win_data, held_row, held_col, held_data);
        end
        if (win_ready) begin
          if (sb.size() != 0) begin
            e = sb.pop_front();
            n_vec++;
            if (win_data !== e.data || win_row !== e.row || win_col !== e.col) begin
              n_fail++;
              $display("FAIL window: got (%0d,%0d) %h want (%0d,%0d) %h",
                       win_row, win_col, win_data, e.row, e.col, e.data);
            end
            if (e.last) begin
              exp_fd  = 1;
              m_drain = 0;
            end
          end
          if (scn_win == 0) begin
            first_data = win_data;
            first_row  = win_row;
            first_col  = win_col;
          end
          last_data = win_data;
          last_row  = win_row;
          last_col  = win_col;
          scn_win++;
        end
        prev_hold = !win_ready;
        held_data = win_data;
        held_row  = win_row;
        held_col  = win_col;
      end else begin
        prev_hold = 0;
      end
      if (in_valid && in_ready) model_accept(in_sof, in_pixel);
    end
  end

  // Downstream ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1 && stall_armed && win_valid) begin
        stall_armed = 0;
        win_ready   = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        win_ready = 1'b1;
      end else if (rdy_mode == 2) begin
        win_ready = ($urandom_range(99) < 70);
      end else begin
        win_ready = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [MASKLEN-1:0] got, input logic [MASKLEN-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push_pixel(input bit sof, input logic [BITS-1:0] pix, input int idle_pct);
    int  tries;
    bit  done;
    while ($urandom_range(99) < idle_pct) begin
      in_valid = 1'b0;
      in_pixel = BITS'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_sof   = sof;
    in_pixel = pix;
    tries    = 0;
    done     = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
      tries++;
      if (!done && tries > 100) begin
        n_vec++;
        n_fail++;
        $display("FAIL push_pixel timeout: in_ready got 0 want 1");
        done = 1;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_part(input int stop_r, input int stop_c, input int idle_pct);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        if (r < stop_r || (r == stop_r && c < stop_c))
          push_pixel(r == 0 && c == 0, BITS'(r*16 + c), idle_pct);
  endtask

  task automatic start_scn();
    scn_win  = 0;
    fd_count = 0;
  endtask

  task automatic finish_scn(input string name, input int exp_win);
    int t = 0;
    while ((sb.size() != 0 || m_drain || win_valid) && t < 500) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, " drain timeout"}, MASKLEN'(t >= 500), '0);
    check({name, " window count"}, MASKLEN'(scn_win), MASKLEN'(exp_win));
    check({name, " frame_done count"}, MASKLEN'(fd_count), MASKLEN'(1));
    check({name, " leftover expected"}, MASKLEN'(sb.size()), '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset win_valid", MASKLEN'(win_valid), '0);
    check("reset frame_done", MASKLEN'(frame_done), '0);
    check("reset win_data", win_data, '0);
    check("reset win_row", MASKLEN'(win_row), '0);
    check("reset win_col", MASKLEN'(win_col), '0);
    check("reset in_ready", MASKLEN'(in_ready), MASKLEN'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // plain frame
    start_scn();
    send_part(IMG_H, 0, 0);
    finish_scn("plain", 8);
    check("first row", MASKLEN'(first_row), MASKLEN'(3));
    check("first col", MASKLEN'(first_col), MASKLEN'(3));
    check("first e00", MASKLEN'(first_data[7:0]), MASKLEN'(8'h00));
    check("first e66", MASKLEN'(first_data[E66 +: BITS]), MASKLEN'(8'h66));
    check("last row", MASKLEN'(last_row), MASKLEN'(4));
    check("last col", MASKLEN'(last_col), MASKLEN'(6));
    check("last e66", MASKLEN'(last_data[E66 +: BITS]), MASKLEN'(8'h79));

    // back-pressure on the first window
    start_scn();
    rdy_mode    = 1;
    stall_armed = 1;
    send_part(IMG_H, 0, 0);
    finish_scn("backpressure", 8);
    rdy_mode = 0;

    // random input gaps
    start_scn();
    send_part(IMG_H, 0, 30);
    finish_scn("gaps", 8);

    // leading non-sof pixels in IDLE
    start_scn();
    for (int k = 0; k < 5; k++) push_pixel(1'b0, BITS'($urandom), 0);
    send_part(IMG_H, 0, 0);
    finish_scn("idle drop", 8);

    // restart at (5,2) then a full frame
    start_scn();
    send_part(5, 2, 0);
    send_part(IMG_H, 0, 0);
    finish_scn("restart 5,2", 8);

    // restart inside the emitting rows with random stalls both sides
    start_scn();
    rdy_mode = 2;
    send_part(6, 8, 30);
    send_part(IMG_H, 0, 30);
    finish_scn("restart 6,8", 10);
    rdy_mode = 0;

    // asynchronous reset with a window pending
    start_scn();
    send_part(6, 8, 0);
    check("pre-reset win_valid", MASKLEN'(win_valid), MASKLEN'(1));
    #2;
    rst = 1'b0;
    #1;
    check("async reset win_valid", MASKLEN'(win_valid), '0);
    check("async reset frame_done", MASKLEN'(frame_done), '0);
    sb.delete();
    m_active = 0;
    m_drain  = 0;
    exp_fd   = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post-reset in_ready", MASKLEN'(in_ready), MASKLEN'(1));
    @(posedge clk);
    #1;
    start_scn();
    send_part(IMG_H, 0, 0);
    finish_scn("after reset", 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
